rotor_stage: RTL
================

Name: rotor_stage

Overview:
- Parametrised, steppable, programmable substitution stage for the Enigma datapath. It generalises the fixed reflector mapping.
- Holds a writable wiring table with its automatically maintained inverse, and a rotor position counter with notch carry-out.
- Provides registered forward (keyboard→reflector) and reverse (reflector→lamp) lookups.
- Rotor stages are chained by carry_out→step_in; the reflector sits after the last stage.

Parameters:
N_SYM, 26, alphabet size; symbols encoded 1..N_SYM, 0 = invalid/none
W, 5, symbol/position width (2^W > N_SYM)
NOTCH, 16, position (0-based) from which a step raises carry_out
RESET_POS, 0, position loaded at reset

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
step_in  in  1  advance position by one (single-cycle pulse)
pos_load  in  1  load position from pos_value
pos_value  in  W  new position, 0..N_SYM-1
pos  out  W  current position
carry_out  out  1  one-cycle pulse: stepped off NOTCH
cfg_we  in  1  write one wiring entry
cfg_index  in  W  wiring input contact, 1..N_SYM
cfg_data  in  W  wiring output contact, 1..N_SYM
in_valid  in  1  lookup request
dir  in  1  0 = forward, 1 = reverse
sym_in  in  W  symbol to map
out_valid  out  1  result valid
sym_out  out  W  mapped symbol, 0 on error
err  out  1  with out_valid: invalid input or lookup during cfg_we

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pos=RESET_POS; carry_out=0; out_valid=0; sym_out=0; err=0.
  - fwd[i]=i and inv[i]=i for all i (identity wiring).
  - Reset has priority over every other input; a reset mid-lookup discards the pending result.
- Position update, per edge, in priority order:
  - pos_load: pos←pos_value; carry_out←0. A pos_value ≥ N_SYM loads 0.
  - else step_in: pos←(pos==N_SYM-1)?0:pos+1; carry_out←(pos==NOTCH).
  - else: carry_out←0.
- Configuration: cfg_we=1 at an edge writes fwd[cfg_index]←cfg_data and inv[cfg_data]←cfg_index.
  - The write is ignored if either value is 0 or >N_SYM.
  - Software must write a full permutation; table consistency is guaranteed only then.
- Lookup: 1-cycle latency. A request sampled at edge k gives out_valid=1 and sym_out/err during cycle k+1. out_valid deasserts the cycle after in_valid drops.
- Mapping uses the pos value before the same edge, so a simultaneous step or load affects only later lookups.
- Lookup arithmetic (all mod N_SYM, W+1-bit intermediates, no divider; conditional subtract/add only):
  - s = ((sym_in-1+pos) mod N_SYM)+1
  - t = dir ? inv[s] : fwd[s]
  - sym_out = ((t-1-pos) mod N_SYM)+1
- Error conditions: sym_in==0, sym_in>N_SYM, or cfg_we=1 in the same cycle → sym_out=0, err=1, out_valid=1.
- Tables: N_SYM×W register arrays indexed 1..N_SYM. Index 0 is unused.
- No handshake backpressure: the stage accepts one lookup every cycle.

Test Plan:
- Reset, then in_valid with dir=0, sym_in=5 → next cycle out_valid=1, sym_out=5, err=0, pos=0, carry_out=0.
- Write (1→2) and (2→1), pos=0; forward lookups sym_in 1,2,3 on consecutive cycles → 2,1,3 each one cycle later. Reverse lookup sym_in 2 → 1.
- Same wiring, pos_load pos_value=1. Forward sym_in=26 → 1. Reverse sym_in=1 → 26. Forward sym_in=25 → 25.
- pos_load 16, then step_in → pos=17, carry_out=1 for exactly one cycle. Next step_in → pos=18, carry_out=0.
- pos_load 25, step_in → pos=0, carry_out=0. pos_load and step_in in the same cycle with pos_value=7 → pos=7.
- Invalid and reset cases:
  - sym_in=0 → err=1, sym_out=0.
  - sym_in=27 → err=1.
  - Lookup with cfg_we=1 → err=1.
  - rst_n low the cycle after a valid request → out_valid=0 and wiring back to identity (sym_in 1 → 1).

Source files
------------

// File: rtl/rotor_stage.sv
// Programmable Enigma substitution stage: writable wiring table with its inverse,
// a rotor position counter with notch carry, and registered forward/reverse lookups.
module rotor_stage #(
    parameter int N_SYM     = 26,
    parameter int W         = 5,
    parameter int NOTCH     = 16,
    parameter int RESET_POS = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_in,
    input  logic         pos_load,
    input  logic [W-1:0] pos_value,
    output logic [W-1:0] pos,
    output logic         carry_out,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_index,
    input  logic [W-1:0] cfg_data,
    input  logic         in_valid,
    input  logic         dir,
    input  logic [W-1:0] sym_in,
    output logic         out_valid,
    output logic [W-1:0] sym_out,
    output logic         err
);

    localparam logic [W:0]   NS      = (W+1)'(N_SYM);
    localparam logic [W:0]   ONE     = (W+1)'(1);
    localparam logic [W-1:0] LAST    = W'(N_SYM - 1);
    localparam logic [W-1:0] NOTCH_P = W'(NOTCH);
    localparam logic [W-1:0] RST_P   = W'(RESET_POS);

    logic [W-1:0] fwd_q [1:N_SYM];
    logic [W-1:0] inv_q [1:N_SYM];

    logic [W-1:0] pos_q, pos_d;
    logic         carry_q, carry_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] sym_out_q, sym_out_d;
    logic         err_q, err_d;

    logic         sym_ok, cfg_ok;
    logic [W:0]   sum_a, sum_b;
    logic [W-1:0] s_idx, t_val, res;

    always_comb begin
        pos_d   = pos_q;
        carry_d = 1'b0;
        if (pos_load) begin
            pos_d = ({1'b0, pos_value} >= NS) ? '0 : pos_value;
        end else if (step_in) begin
            pos_d   = (pos_q == LAST) ? '0 : pos_q + 1'b1;
            carry_d = (pos_q == NOTCH_P);
        end
    end

    // Both modular steps stay within W+1 bits, so one conditional subtract suffices.
    always_comb begin
        sym_ok = (sym_in != '0) && ({1'b0, sym_in} <= NS);
        cfg_ok = (cfg_index != '0) && ({1'b0, cfg_index} <= NS) &&
                 (cfg_data != '0) && ({1'b0, cfg_data} <= NS);

        sum_a = {1'b0, sym_in} - ONE + {1'b0, pos_q};
        if (sum_a >= NS) sum_a = sum_a - NS;
        s_idx = sum_a[W-1:0] + 1'b1;

        t_val = dir ? inv_q[s_idx] : fwd_q[s_idx];

        sum_b = {1'b0, t_val} - ONE + (NS - {1'b0, pos_q});
        if (sum_b >= NS) sum_b = sum_b - NS;
        res = sum_b[W-1:0] + 1'b1;

        out_valid_d = in_valid;
        sym_out_d   = '0;
        err_d       = 1'b0;
        if (in_valid) begin
            if (!sym_ok || cfg_we) err_d = 1'b1;
            else                   sym_out_d = res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q       <= RST_P;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sym_out_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 1; i <= N_SYM; i++) begin
                fwd_q[i] <= W'(i);
                inv_q[i] <= W'(i);
            end
        end else begin
            pos_q       <= pos_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            sym_out_q   <= sym_out_d;
            err_q       <= err_d;
            if (cfg_we && cfg_ok) begin
                fwd_q[cfg_index] <= cfg_data;
                inv_q[cfg_data]  <= cfg_index;
            end
        end
    end

    assign pos       = pos_q;
    assign carry_out = carry_q;
    assign out_valid = out_valid_q;
    assign sym_out   = sym_out_q;
    assign err       = err_q;

endmodule
